// File: rtl/cpu7_icu_fetch_pkg.sv
// Shared beat/block widths and fetch FSM state encoding for the ICU fetch path.
package cpu7_icu_fetch_pkg;

  localparam int BEAT_W  = 32;
  localparam int BLOCK_W = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
    RESP    = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  function automatic logic [31:0] block_base(input logic [31:0] addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/cpu7_icu_linebuf.sv
// One-entry line buffer (tag, valid, 64-bit block) used when ICU_LINE_BUF_EN is defined.
module cpu7_icu_linebuf
  import cpu7_icu_fetch_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic [28:0]        lookup_tag,
  input  logic               inval,
  input  logic               fill,
  input  logic [28:0]        fill_tag,
  input  logic [BLOCK_W-1:0] fill_data,
  output logic               hit,
  output logic [BLOCK_W-1:0] rd_data
);

  logic               valid;
  logic [28:0]        tag;
  logic [BLOCK_W-1:0] data;

  // Invalidate wins over a same-cycle fill so a barrier is never lost.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      tag   <= '0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
    end
  end

  // NOTE: the payload is not reset; valid alone decides whether it is ever used.
  always_ff @(posedge clock) begin
    if (fill) data <= fill_data;
  end

  assign hit     = valid & (tag == lookup_tag) & ~inval;
  assign rd_data = data;

endmodule

// File: rtl/cpu7_icu_fetch.sv
// ICU fetch: turns one IFU block request into two 32-bit memory beats (lo, hi).
// Optional one-entry line buffer enabled by defining ICU_LINE_BUF_EN.
module cpu7_icu_fetch
  import cpu7_icu_fetch_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               ifu_icu_req_ic1,
  input  logic [31:0]        ifu_icu_addr_ic1,
  output logic               icu_ifu_ack_ic1,
  input  logic               ifu_icu_cancel,
  output logic [BLOCK_W-1:0] icu_ifu_data_ic2,
  output logic               icu_ifu_data_valid_ic2,
  output logic               icu_mem_req,
  output logic [31:0]        icu_mem_addr,
  input  logic               mem_icu_gnt,
  input  logic [BEAT_W-1:0]  mem_icu_rdata,
  input  logic               mem_icu_rvalid,
  input  logic               exu_icu_ibar
);

  state_t             state, state_nxt;
  logic [31:0]        base;
  logic [BLOCK_W-1:0] blk;
  logic               drain_hi, drain_gnt;
  logic               ack, hit, mem_req, beat_hi;
  logic [BLOCK_W-1:0] buf_data;

  assign ack = ifu_icu_req_ic1 & (state == IDLE) & ~ifu_icu_cancel;

`ifdef ICU_LINE_BUF_EN
  logic fill;
  logic unused_addr_lo;

  // Only a block that actually reaches the IFU is worth remembering.
  assign fill           = (state == RESP) & ~ifu_icu_cancel;
  assign unused_addr_lo = ^ifu_icu_addr_ic1[2:0];

  cpu7_icu_linebuf u_linebuf (
    .clock      (clock),
    .resetn     (resetn),
    .lookup_tag (ifu_icu_addr_ic1[31:3]),
    .inval      (exu_icu_ibar),
    .fill       (fill),
    .fill_tag   (base[31:3]),
    .fill_data  (blk),
    .hit        (hit),
    .rd_data    (buf_data)
  );
`else
  logic unused_inputs;

  assign hit           = 1'b0;
  assign buf_data      = '0;
  assign unused_inputs = ^{ifu_icu_addr_ic1[2:0], exu_icu_ibar};
`endif

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    beat_hi   = 1'b0;
    case (state)
      IDLE: begin
        if (ack) state_nxt = hit ? RESP : REQ_LO;
      end
      REQ_LO: begin
        mem_req = 1'b1;
        if (ifu_icu_cancel)   state_nxt = DRAIN;
        else if (mem_icu_gnt) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        // A cancel that coincides with rvalid has nothing left to drain.
        if (ifu_icu_cancel)      state_nxt = mem_icu_rvalid ? IDLE : DRAIN;
        else if (mem_icu_rvalid) state_nxt = REQ_HI;
      end
      REQ_HI: begin
        mem_req = 1'b1;
        beat_hi = 1'b1;
        if (ifu_icu_cancel)   state_nxt = DRAIN;
        else if (mem_icu_gnt) state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (ifu_icu_cancel)      state_nxt = mem_icu_rvalid ? IDLE : DRAIN;
        else if (mem_icu_rvalid) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      DRAIN: begin
        // Finish the abandoned beat's handshake, then drop its data.
        mem_req = ~drain_gnt;
        beat_hi = drain_hi;
        if (drain_gnt && mem_icu_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      base      <= '0;
      blk       <= '0;
      drain_hi  <= 1'b0;
      drain_gnt <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ack) base <= block_base(ifu_icu_addr_ic1);
      if (ack && hit) blk <= buf_data;
      if (state == WAIT_LO && mem_icu_rvalid) blk[BEAT_W-1:0] <= mem_icu_rdata;
      if (state == WAIT_HI && mem_icu_rvalid) blk[BLOCK_W-1:BEAT_W] <= mem_icu_rdata;
      if (state_nxt == DRAIN && state != DRAIN) begin
        drain_hi  <= (state == REQ_HI) || (state == WAIT_HI);
        drain_gnt <= (state == WAIT_LO) || (state == WAIT_HI) || mem_icu_gnt;
      end else if (state == DRAIN && mem_req && mem_icu_gnt) begin
        drain_gnt <= 1'b1;
      end
    end
  end

  assign icu_ifu_ack_ic1        = ack;
  assign icu_mem_req            = mem_req;
  assign icu_mem_addr           = mem_req ? (base + (beat_hi ? 32'd4 : 32'd0)) : 32'd0;
  assign icu_ifu_data_ic2       = blk;
  assign icu_ifu_data_valid_ic2 = (state == RESP) & ~ifu_icu_cancel;

endmodule
